// File: rtl/output_serializer_pkg.sv
// rtl/output_serializer_pkg.sv - shared types and constants for the output serializer
//
// Contents:
//   ser_state_e        FSM state encoding (IDLE: no word held, SEND: beats pending)
//   DEF_DATA_WIDTH     default word width drained from the output FIFO
//   DEF_BYTE_WIDTH     default beat width
//   DEF_BEATS_PER_WORD beats per word for the default widths
//   WORD_COUNT_WIDTH   width of the transmitted-word counter
//   beats_per_word()   beats per word for arbitrary widths
//   beat_cnt_width()   width of a counter able to index every beat of a word

package output_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_BYTE_WIDTH     = 8;
    localparam int unsigned DEF_BEATS_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;
    localparam int unsigned WORD_COUNT_WIDTH   = 16;

    function automatic int unsigned beats_per_word(input int unsigned data_width,
                                                   input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

    // A one-beat word still needs a 1-bit counter so the port is never zero width.
    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/output_serializer_shift_unit.sv
// rtl/output_serializer_shift_unit.sv - loadable left-shift register with beat counter
//
// Ports:
//   clk        clock, state updates on rising edge
//   rst        synchronous active-high reset: register and counter cleared
//   load       load load_data into the register and clear the beat counter
//   shift      shift the register left by one beat and increment the counter
//   load_data  word to load
//   head_beat  most significant beat of the held word (the beat on the wire)
//   beat_cnt   index of the beat currently at the head
//
// load has priority over shift; the owner never asserts both in one cycle.

module shift_unit #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned CntWidth  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DataWidth-1:0] load_data,
    output logic [ByteWidth-1:0] head_beat,
    output logic [CntWidth-1:0]  beat_cnt
);

    logic [DataWidth-1:0] shreg_q, shreg_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = '0;
        end else if (shift) begin
            shreg_d = shreg_q << ByteWidth;
            cnt_d   = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head_beat = shreg_q[DataWidth-1 -: ByteWidth];
    assign beat_cnt  = cnt_q;

endmodule

// File: rtl/output_serializer.sv
// rtl/output_serializer.sv - drains words from an output FIFO and serializes them MSB-first
//
// Parameters:
//   DataWidth   width of words popped from the FIFO (integer multiple of ByteWidth)
//   ByteWidth   width of each serialized beat
//   BufferSize  width of the FIFO per-slot occupancy vector
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   ReadyM     FIFO occupancy; a word is available when any bit is set
//   DataOut2   FIFO head word, valid while a word is available
//   Pop2       pop strobe to the FIFO; head advances on the same edge
//   ByteOut    current beat
//   ByteValid  ByteOut is valid
//   ByteReady  downstream accepts the beat when ByteValid and ByteReady are both high
//   ByteLast   final beat of the current word
//   WordCount  words fully transmitted since reset, modulo 2^16

module output_serializer
    import output_serializer_pkg::*;
#(
    parameter int unsigned DataWidth  = DEF_DATA_WIDTH,
    parameter int unsigned ByteWidth  = DEF_BYTE_WIDTH,
    parameter int unsigned BufferSize = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BufferSize-1:0]       ReadyM,
    input  logic [DataWidth-1:0]        DataOut2,
    output logic                        Pop2,
    output logic [ByteWidth-1:0]        ByteOut,
    output logic                        ByteValid,
    input  logic                        ByteReady,
    output logic                        ByteLast,
    output logic [WORD_COUNT_WIDTH-1:0] WordCount
);

    localparam int unsigned          Beats    = beats_per_word(DataWidth, ByteWidth);
    localparam int unsigned          CntWidth = beat_cnt_width(Beats);
    localparam logic [CntWidth-1:0]  LastCnt  = CntWidth'(Beats - 1);

    ser_state_e                  state_q, state_d;
    logic [WORD_COUNT_WIDTH-1:0] word_count_q, word_count_d;

    logic                 avail;
    logic                 in_send;
    logic                 is_last;
    logic                 byte_valid;
    logic                 accept;
    logic                 word_done;
    logic                 pop;
    logic                 shift;
    logic [ByteWidth-1:0] head_beat;
    logic [CntWidth-1:0]  beat_cnt;

    assign avail = |ReadyM;

    // Handshake and pop decisions. Everything visible outside is gated by rst
    // so the interface is quiet for the whole reset window, including the
    // first cycle before the registers have cleared.
    always_comb begin
        in_send    = (state_q == ST_SEND);
        is_last    = in_send && (beat_cnt == LastCnt);
        byte_valid = !rst && in_send;
        accept     = byte_valid && ByteReady;
        word_done  = accept && is_last;
        // Pop only when nothing is held or the held word just finished, so a
        // word with unsent beats is never overwritten; the reload on word_done
        // gives back-to-back words without a bubble.
        pop        = !rst && avail && (!in_send || word_done);
        shift      = accept && !is_last;
    end

    shift_unit #(
        .DataWidth (DataWidth),
        .ByteWidth (ByteWidth),
        .CntWidth  (CntWidth)
    ) u_shift_unit (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .shift     (shift),
        .load_data (DataOut2),
        .head_beat (head_beat),
        .beat_cnt  (beat_cnt)
    );

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        case (state_q)
            ST_IDLE: begin
                if (avail) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (word_done) begin
                    word_count_d = word_count_q + WORD_COUNT_WIDTH'(1);
                    state_d      = avail ? ST_SEND : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
        end
    end

    assign Pop2      = pop;
    assign ByteValid = byte_valid;
    assign ByteLast  = !rst && is_last;
    assign ByteOut   = rst ? '0 : head_beat;
    assign WordCount = rst ? '0 : word_count_q;

endmodule

// File: tb/tb_output_serializer.sv
// tb/tb_output_serializer.sv - self-checking bench for output_serializer

module tb_output_serializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  ReadyM;
    logic [31:0] DataOut2;
    logic        Pop2;
    logic [7:0]  ByteOut;
    logic        ByteValid;
    logic        ByteReady;
    logic        ByteLast;
    logic [15:0] WordCount;

    output_serializer #(.DataWidth(32), .ByteWidth(8), .BufferSize(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ReadyM    (ReadyM),
        .DataOut2  (DataOut2),
        .Pop2      (Pop2),
        .ByteOut   (ByteOut),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .ByteLast  (ByteLast),
        .WordCount (WordCount)
    );

    logic        w_rst;
    logic [3:0]  w_readym;
    logic [7:0]  w_data;
    logic        w_pop;
    logic [7:0]  w_byte;
    logic        w_valid;
    logic        w_ready;
    logic        w_last;
    logic [15:0] w_wc;

    output_serializer #(.DataWidth(8), .ByteWidth(8), .BufferSize(4)) dut_wrap (
        .clk       (clk),
        .rst       (w_rst),
        .ReadyM    (w_readym),
        .DataOut2  (w_data),
        .Pop2      (w_pop),
        .ByteOut   (w_byte),
        .ByteValid (w_valid),
        .ByteReady (w_ready),
        .ByteLast  (w_last),
        .WordCount (w_wc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0]  pend[$];
    int          mcount;
    logic [31:0] fifo[$];

    bit          d_rst, d_ready, d_avail_en;
    logic [3:0]  d_mask;
    int          cyc;

    logic [7:0]  acc_vals[$];
    int          acc_cyc[$];
    bit          acc_last[$];
    int          pop_cyc[$];

    bit          s_rst, s_acc, s_epop, s_pop;
    logic [31:0] s_head;
    bit          wrap_done;

    task automatic clear_logs();
        acc_vals.delete();
        acc_cyc.delete();
        acc_last.delete();
        pop_cyc.delete();
    endtask

    task automatic apply_inputs();
        rst       = d_rst;
        ByteReady = d_ready;
        if (fifo.size() > 0 && d_avail_en) begin
            ReadyM   = d_mask;
            DataOut2 = fifo[0];
        end else begin
            ReadyM   = 4'h0;
            DataOut2 = $urandom();
        end
    endtask

    task automatic tick();
        logic       e_valid, e_last, e_pop, avail;
        logic [7:0] e_out;
        logic [15:0] e_wc;
        apply_inputs();
        #1;
        @(negedge clk);
        avail   = |ReadyM;
        e_valid = !rst && pend.size() > 0;
        e_last  = e_valid && pend.size() == 1;
        e_pop   = !rst && avail && (pend.size() == 0 || (ByteReady && pend.size() == 1));
        e_out   = e_valid ? pend[0] : 8'h00;
        e_wc    = rst ? 16'h0 : mcount[15:0];
        chk("Pop2", Pop2, e_pop);
        chk("ByteValid", ByteValid, e_valid);
        chk("ByteLast", ByteLast, e_last);
        chk("WordCount", WordCount, e_wc);
        if (e_valid || rst) chk("ByteOut", ByteOut, e_out);
        if (ByteValid && ByteReady) begin
            acc_vals.push_back(ByteOut);
            acc_cyc.push_back(cyc);
            acc_last.push_back(ByteLast);
        end
        if (Pop2) pop_cyc.push_back(cyc);
        s_rst  = rst;
        s_acc  = e_valid && ByteReady;
        s_epop = e_pop;
        s_pop  = Pop2;
        s_head = DataOut2;
        cyc++;
        @(posedge clk);
        if (s_rst) begin
            pend.delete();
            mcount = 0;
        end else begin
            if (s_acc) begin
                void'(pend.pop_front());
                if (pend.size() == 0) mcount++;
            end
            if (s_epop) begin
                for (int b = 0; b < 4; b++) pend.push_back(s_head[31 - 8*b -: 8]);
            end
        end
        if (s_pop && fifo.size() > 0) void'(fifo.pop_front());
        #1;
    endtask

    task automatic check_word_seq(input string name, input logic [31:0] w, input int base);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ww;
            ww = w;
            if (base + i < acc_vals.size()) chk(name, acc_vals[base+i], ww[31 - 8*i -: 8]);
            else chk({name, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        bit found;
        mcount     = 0;
        cyc        = 0;
        d_rst      = 1'b1;
        d_ready    = 1'b1;
        d_avail_en = 1'b1;
        d_mask     = 4'hF;
        fifo.push_back(32'hA1B2C3D4);
        apply_inputs();
        @(posedge clk);
        #1;

        // Reset held with a word available
        clear_logs();
        repeat (3) tick();
        chk("reset_no_pop", pop_cyc.size(), 0);
        chk("reset_no_beat", acc_vals.size(), 0);
        chk("reset_wc", WordCount, 0);

        // Single word
        d_rst  = 1'b0;
        d_mask = 4'b0001;
        clear_logs();
        repeat (7) tick();
        chk("single_pops", pop_cyc.size(), 1);
        chk("single_beats", acc_vals.size(), 4);
        check_word_seq("single_beat", 32'hA1B2C3D4, 0);
        for (int i = 0; i < acc_cyc.size() && i < 4; i++) begin
            chk("single_consecutive", acc_cyc[i] - acc_cyc[0], i);
            chk("single_last", acc_last[i], i == 3);
        end
        if (pop_cyc.size() > 0 && acc_cyc.size() > 0)
            chk("single_latency", acc_cyc[0] - pop_cyc[0], 1);
        chk("single_wc", WordCount, 1);
        chk("single_idle", ByteValid, 0);

        // Back-to-back words
        clear_logs();
        fifo.push_back(32'h11223344);
        fifo.push_back(32'h55667788);
        d_mask = 4'b0011;
        repeat (12) tick();
        chk("b2b_beats", acc_vals.size(), 8);
        for (int i = 0; i < acc_vals.size() && i < 8; i++) begin
            chk("b2b_val", acc_vals[i], 8'h11 * (i + 1));
            chk("b2b_no_bubble", acc_cyc[i] - acc_cyc[0], i);
        end
        chk("b2b_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() > 1 && acc_cyc.size() > 3)
            chk("b2b_pop_on_44", pop_cyc[1], acc_cyc[3]);
        chk("b2b_wc", WordCount, 3);

        // Backpressure on beat B2
        clear_logs();
        fifo.push_back(32'hA1B2C3D4);
        d_mask = 4'b1000;
        found  = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (ByteValid && ByteOut == 8'hB2) found = 1'b1;
        end
        chk("bp_reach_b2", found, 1);
        d_ready = 1'b0;
        repeat (5) tick();
        chk("bp_hold_out", ByteOut, 8'hB2);
        chk("bp_hold_valid", ByteValid, 1);
        chk("bp_no_extra_pop", pop_cyc.size(), 1);
        d_ready = 1'b1;
        repeat (6) tick();
        check_word_seq("bp_beat", 32'hA1B2C3D4, 0);
        if (acc_cyc.size() > 1) chk("bp_stall_len", acc_cyc[1] - acc_cyc[0], 6);
        chk("bp_wc", WordCount, 4);

        // Reset mid-word after B2 accepted
        clear_logs();
        fifo.push_back(32'hA1B2C3D4);
        for (int k = 0; k < 10 && acc_vals.size() < 2; k++) tick();
        chk("rmw_two_beats", acc_vals.size(), 2);
        d_rst = 1'b1;
        tick();
        chk("rmw_valid", ByteValid, 0);
        chk("rmw_wc", WordCount, 0);
        repeat (2) tick();
        chk("rmw_pops", pop_cyc.size(), 1);
        chk("rmw_beats", acc_vals.size(), 2);
        d_rst = 1'b0;
        repeat (3) tick();
        chk("rmw_after_wc", WordCount, 0);
        chk("rmw_after_valid", ByteValid, 0);

        // Randomized traffic with stalls and occasional resets
        for (int k = 0; k < 3000; k++) begin
            d_ready    = ($urandom_range(0, 9) < 7);
            d_avail_en = ($urandom_range(0, 9) < 8);
            d_mask     = 4'($urandom_range(1, 15));
            d_rst      = ($urandom_range(0, 399) == 0);
            if (fifo.size() < 4 && $urandom_range(0, 2) == 0) fifo.push_back($urandom());
            tick();
        end

        // Sustained streaming: throughput must be one beat per cycle
        d_rst      = 1'b0;
        d_ready    = 1'b1;
        d_avail_en = 1'b1;
        repeat (4) tick();
        clear_logs();
        for (int k = 0; k < 40; k++) begin
            while (fifo.size() < 3) fifo.push_back($urandom());
            d_mask = 4'($urandom_range(1, 15));
            tick();
        end
        chk("stream_throughput", acc_vals.size(), 40);

        while (!wrap_done) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // One-beat words streamed continuously to walk WordCount through its wrap.
    initial begin
        int total;
        int bubbles;
        wrap_done = 1'b0;
        w_rst     = 1'b1;
        w_readym  = 4'b0001;
        w_ready   = 1'b1;
        w_data    = 8'($urandom());
        repeat (2) @(posedge clk);
        #1;
        w_rst   = 1'b0;
        total   = 0;
        bubbles = 0;
        for (int c = 0; c < 70000 && total <= 65536; c++) begin
            @(negedge clk);
            if (c > 0 && !w_valid) bubbles++;
            if (total % 8192 == 0 || total == 65535) chk("wrap_wc", w_wc, total[15:0]);
            if (w_valid && w_ready && w_last) total++;
            @(posedge clk);
            #1;
            w_data = 8'($urandom());
        end
        chk("wrap_reached", total > 65536, 1);
        chk("wrap_bubbles", bubbles, 0);
        wrap_done = 1'b1;
    end

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 Parameter DataWidth, default 32, width of words drained from the output FIFO.
REQ-002 Parameter ByteWidth, default 8, width of each serialized beat; DataWidth SHALL be an integer multiple of ByteWidth.
REQ-003 Parameter BufferSize, default 4, width of the FIFO occupancy vector.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ReadyM  input  BufferSize  per-slot occupancy from the output FIFO; word available when any bit set.
REQ-007 DataOut2  input  DataWidth  head word of the output FIFO, valid combinationally while available.
REQ-008 Pop2  output  1  one-cycle pop strobe to the output FIFO; head advances on the same edge.
REQ-009 ByteOut  output  ByteWidth  current beat, MSB-first slice of the held word.
REQ-010 ByteValid  output  1  ByteOut is valid.
REQ-011 ByteReady  input  1  downstream accepts the beat on an edge where ByteValid and ByteReady are both high.
REQ-012 ByteLast  output  1  high with the final beat of each word.
REQ-013 WordCount  output  16  number of words fully transmitted since reset, wraps modulo 2^16.

Function
REQ-014 Avail SHALL be the OR-reduction of ReadyM.
REQ-015 The FSM SHALL have two states: IDLE (no word held) and SEND (word held in shift register, beats pending).
REQ-016 In IDLE with Avail=1, Pop2 SHALL be 1 combinationally; on that edge DataOut2 loads the shift register, the beat counter clears to 0, and the state goes to SEND.
REQ-017 In IDLE with Avail=0, Pop2=0 and the state holds.
REQ-018 In SEND, ByteValid=1 and ByteOut=shift register[DataWidth-1 -: ByteWidth].
REQ-019 On an accepted beat that is not the last, the shift register SHALL shift left by ByteWidth and the beat counter SHALL increment.
REQ-020 ByteLast SHALL be 1 when the beat counter equals DataWidth/ByteWidth-1 and the state is SEND.
REQ-021 On acceptance of the last beat, WordCount SHALL increment; if Avail=1 in that cycle, Pop2=1 and the next word loads on the same edge with the state staying in SEND (zero-bubble back-to-back); otherwise the state returns to IDLE.
REQ-022 With ByteValid=1 and ByteReady=0, ByteOut, ByteLast and all state SHALL hold unchanged.
REQ-023 Pop2 SHALL never be asserted while a word with unsent beats is held, nor when Avail=0.
REQ-024 Latency from Avail rising in IDLE to the first ByteValid SHALL be exactly 1 cycle.
REQ-025 Sustained throughput SHALL be one beat per cycle with ByteReady held high and Avail continuously high.

Reset
REQ-026 While rst=1: state=IDLE, shift register=0, beat counter=0, WordCount=0, ByteValid=0, ByteLast=0, ByteOut=0, Pop2=0.
REQ-027 Asserting rst mid-word SHALL discard the held word without popping or counting it; the FIFO's own reset governs its contents.

Structure
REQ-028 The state encoding and the beats-per-word constant (DataWidth/ByteWidth) SHALL reside in the shared MAC package.
REQ-029 A single sub-module, shift_unit (loadable left-shift register with beat counter), SHALL be instantiated; the FSM, pop logic and WordCount SHALL reside in output_serializer.

Verification
REQ-030 Reset: rst high 3 cycles with ReadyM=4'b1111 -> Pop2=0, ByteValid=0, WordCount=0 throughout.
REQ-031 Single word: ReadyM=4'b0001, DataOut2=32'hA1B2C3D4, ByteReady=1 -> Pop2 one cycle; beats A1,B2,C3,D4 on 4 consecutive cycles; ByteLast only on D4; WordCount=1; return to IDLE.
REQ-032 Back-to-back: two words 32'h11223344, 32'h55667788 queued -> 8 consecutive beats 11..88 with no bubble; second Pop2 coincides with the beat 44 acceptance; WordCount=2.
REQ-033 Backpressure: ByteReady=0 for 5 cycles during beat B2 -> ByteOut stays B2, no Pop2, then resumes C3, D4.
REQ-034 Reset mid-word: rst asserted after beat B2 accepted -> next cycle ByteValid=0, WordCount=0, no Pop2 during reset.
REQ-035 Counter wrap: 65536 words drained -> WordCount returns to 0.
